alu_seq_unit: RTL and testbench

- Parametrised, registered successor to the single-cycle ALU.
- Decodes the MIPS opcode/funct pair internally and executes single-cycle logic and arithmetic ops with one-cycle latency.
- Adds iterative MULT/MULTU/DIV/DIVU and the architectural HI/LO registers (MFHI/MFLO), coordinated by a start/ready/valid handshake.
- Sits between the register-file read stage and writeback in the multi-cycle datapath.

---
 rtl/alu_seq_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//
// Registered ALU for the multi-cycle datapath. It decodes the MIPS
// opcode/funct pair itself and supports:
//   - single-cycle logic and arithmetic ops, with one cycle of latency;
//   - iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring), each taking
//     WIDTH cycles;
//   - the architectural HI/LO registers, read back with MFHI/MFLO.
//
// Handshake (valid/ready):
//   - A request is accepted on a rising edge where start=1 and ready=1.
//     Operands and codes are sampled only on that edge.
//   - A start while ready=0 is dropped. It is not queued.
//   - valid is high for exactly one cycle after the edge that updates
//     result/zero/overflow. Between pulses those outputs hold their values.
//   - ready is low only while a multiply or divide is iterating.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request strobe
//   opcode     : instruction opcode
//   func_field : R-type funct field
//   A, B       : operands (rs, and rt or the extended immediate)
//   ready      : idle, can accept start
//   valid      : one-cycle pulse, result/zero/overflow updated
//   result     : registered result
//   zero       : registered (result == 0)
//   overflow   : registered signed overflow (ADD/ADDI/SUB)
//   hi, lo     : HI and LO registers
// -----------------------------------------------------------------------------
module alu_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func_field,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   typedef enum logic [4:0] {
      OP_NONE,
      OP_ADD,
      OP_ADDU,
      OP_SUB,
      OP_SUBU,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_NOR,
      OP_SLT,
      OP_SLTU,
      OP_MFHI,
      OP_MFLO,
      OP_MULT,
      OP_MULTU,
      OP_DIV,
      OP_DIVU
   } op_t;

   state_t state;
   state_t state_next;
   op_t    op;

   // ---------------------------------------------------------------------------
   // Iteration state
   // ---------------------------------------------------------------------------
   logic [CW-1:0]        iter_cnt;
   logic [2*WIDTH-1:0]   mcand;      // multiplicand magnitude, shifted left each step
   logic [WIDTH-1:0]     mplier;     // multiplier magnitude, shifted right each step
   logic [2*WIDTH-1:0]   prod;       // partial-product accumulator
   logic                 neg_prod;
   logic [WIDTH-1:0]     quot;       // holds the dividend, replaced by quotient bits
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     divisor;
   logic                 neg_quot;
   logic                 neg_rem;

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   always_comb begin
      op = OP_NONE;
      if (opcode == 6'h00) begin
         case (func_field)
            6'h20:   op = OP_ADD;
            6'h21:   op = OP_ADDU;
            6'h22:   op = OP_SUB;
            6'h23:   op = OP_SUBU;
            6'h24:   op = OP_AND;
            6'h25:   op = OP_OR;
            6'h26:   op = OP_XOR;
            6'h27:   op = OP_NOR;
            6'h2A:   op = OP_SLT;
            6'h2B:   op = OP_SLTU;
            6'h10:   op = OP_MFHI;
            6'h12:   op = OP_MFLO;
            6'h18:   op = OP_MULT;
            6'h19:   op = OP_MULTU;
            6'h1A:   op = OP_DIV;
            6'h1B:   op = OP_DIVU;
            default: op = OP_NONE;
         endcase
      end else begin
         case (opcode)
            6'h08:   op = OP_ADD;    // ADDI
            6'h09:   op = OP_ADDU;   // ADDIU
            6'h0C:   op = OP_AND;    // ANDI
            6'h0D:   op = OP_OR;     // ORI
            6'h0E:   op = OP_XOR;    // XORI
            6'h0A:   op = OP_SLT;    // SLTI
            6'h0B:   op = OP_SLTU;   // SLTIU
            6'h04:   op = OP_SUBU;   // BEQ compare
            6'h05:   op = OP_SUBU;   // BNE compare
            6'h23:   op = OP_ADDU;   // LW address
            6'h2B:   op = OP_ADDU;   // SW address
            default: op = OP_NONE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt_bit;
   logic             sltu_bit;
   logic [WIDTH-1:0] sc_result;
   logic             sc_ovf;

   assign sum      = A + B;
   assign diff     = A - B;
   assign slt_bit  = $signed(A) < $signed(B);
   assign sltu_bit = A < B;

   always_comb begin
      sc_result = '0;
      sc_ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            sc_result = sum;
            // Same-signed operands whose sum flips sign.
            sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_ADDU: sc_result = sum;
         OP_SUB: begin
            sc_result = diff;
            // Opposite-signed operands whose difference leaves A's sign.
            sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUBU:  sc_result = diff;
         OP_AND:   sc_result = A & B;
         OP_OR:    sc_result = A | B;
         OP_XOR:   sc_result = A ^ B;
         OP_NOR:   sc_result = ~(A | B);
         OP_SLT:   sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_SLTU:  sc_result = {{(WIDTH-1){1'b0}}, sltu_bit};
         OP_MFHI:  sc_result = hi;
         OP_MFLO:  sc_result = lo;
         default: begin
            sc_result = '0;
            sc_ovf    = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Multiply/divide setup and iteration steps
   // ---------------------------------------------------------------------------
   logic             accept;
   logic             is_mul;
   logic             is_div;
   logic             div_zero;
   logic             signed_md;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic             last_iter;

   assign ready     = (state == S_IDLE);
   assign accept    = start && ready;
   assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
   assign div_zero  = is_div && (B == '0);
   assign signed_md = (op == OP_MULT) || (op == OP_DIV);
   // The most-negative value maps onto itself, which read as unsigned is the
   // correct magnitude 2^(WIDTH-1).
   assign mag_a     = (signed_md && A[WIDTH-1]) ? (~A + 1'b1) : A;
   assign mag_b     = (signed_md && B[WIDTH-1]) ? (~B + 1'b1) : B;
   assign last_iter = (iter_cnt == CW'(WIDTH - 1));

   logic [2*WIDTH-1:0] prod_step;
   logic [2*WIDTH-1:0] mul_final;

   assign prod_step = mplier[0] ? (prod + mcand) : prod;
   assign mul_final = neg_prod ? (~prod_step + 1'b1) : prod_step;

   // Restoring step: shift the next dividend bit into the remainder and keep
   // the trial difference only when it did not borrow.
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] quot_step;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quot_final;
   logic [WIDTH-1:0] rem_final;

   assign rem_shift  = {rem, quot[WIDTH-1]};
   assign trial      = rem_shift - {1'b0, divisor};
   assign quot_step  = {quot[WIDTH-2:0], ~trial[WIDTH]};
   assign rem_step   = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quot_final = neg_quot ? (~quot_step + 1'b1) : quot_step;
   assign rem_final  = neg_rem  ? (~rem_step + 1'b1)  : rem_step;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_next = S_MUL;
               end else if (is_div && !div_zero) begin
                  state_next = S_DIV;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (last_iter) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         iter_cnt <= '0;
         mcand    <= '0;
         mplier   <= '0;
         prod     <= '0;
         neg_prod <= 1'b0;
         quot     <= '0;
         rem      <= '0;
         divisor  <= '0;
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     mcand    <= {{WIDTH{1'b0}}, mag_a};
                     mplier   <= mag_b;
                     prod     <= '0;
                     neg_prod <= signed_md && (A[WIDTH-1] ^ B[WIDTH-1]);
                     iter_cnt <= '0;
                  end else if (is_div && !div_zero) begin
                     quot     <= mag_a;
                     rem      <= '0;
                     divisor  <= mag_b;
                     neg_quot <= signed_md && (A[WIDTH-1] ^ B[WIDTH-1]);
                     neg_rem  <= signed_md && A[WIDTH-1];
                     iter_cnt <= '0;
                  end else if (div_zero) begin
                     // Divide by zero completes at once and never traps.
                     hi       <= A;
                     lo       <= '1;
                     result   <= '1;
                     zero     <= 1'b0;
                     overflow <= 1'b0;
                     valid    <= 1'b1;
                  end else begin
                     result   <= sc_result;
                     zero     <= (sc_result == '0);
                     overflow <= sc_ovf;
                     valid    <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               prod     <= prod_step;
               mcand    <= mcand << 1;
               mplier   <= mplier >> 1;
               iter_cnt <= iter_cnt + CW'(1);
               if (last_iter) begin
                  hi       <= mul_final[2*WIDTH-1:WIDTH];
                  lo       <= mul_final[WIDTH-1:0];
                  result   <= mul_final[WIDTH-1:0];
                  zero     <= (mul_final[WIDTH-1:0] == '0);
                  overflow <= 1'b0;
                  valid    <= 1'b1;
               end
            end
            S_DIV: begin
               quot     <= quot_step;
               rem      <= rem_step;
               iter_cnt <= iter_cnt + CW'(1);
               if (last_iter) begin
                  hi       <= rem_final;
                  lo       <= quot_final;
                  result   <= quot_final;
                  zero     <= (quot_final == '0);
                  overflow <= 1'b0;
                  valid    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_unit
//
// Directed and random checks of alu_seq_unit (WIDTH=32) against a reference
// model built from plain 64-bit arithmetic, with HI/LO tracked in the bench.
// -----------------------------------------------------------------------------
module tb_alu_seq_unit;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [5:0]   opcode;
   logic [5:0]   func_field;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         ready;
   logic         valid;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int total;
   int bad;

   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .opcode     (opcode),
      .func_field (func_field),
      .A          (A),
      .B          (B),
      .ready      (ready),
      .valid      (valid),
      .result     (result),
      .zero       (zero),
      .overflow   (overflow),
      .hi         (hi),
      .lo         (lo)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference model: computes the result from the instruction's meaning.
   task automatic model_op(input logic [5:0] opc, input logic [5:0] fn,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic ov, output int lat);
      logic [5:0]  f;
      longint      sa;
      longint      sb;
      longint      s;
      logic [63:0] p;
      r   = '0;
      ov  = 1'b0;
      lat = 0;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      f   = fn;
      if (opc != 6'h00) begin
         case (opc)
            6'h08:        f = 6'h20;
            6'h09:        f = 6'h21;
            6'h0C:        f = 6'h24;
            6'h0D:        f = 6'h25;
            6'h0E:        f = 6'h26;
            6'h0A:        f = 6'h2A;
            6'h0B:        f = 6'h2B;
            6'h04, 6'h05: f = 6'h23;
            6'h23, 6'h2B: f = 6'h21;
            default:      f = 6'h3F;
         endcase
      end
      case (f)
         6'h20: begin
            s  = sa + sb;
            r  = a + b;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'h21: r = a + b;
         6'h22: begin
            s  = sa - sb;
            r  = a - b;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         6'h23: r = a - b;
         6'h24: r = a & b;
         6'h25: r = a | b;
         6'h26: r = a ^ b;
         6'h27: r = ~(a | b);
         6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
         6'h2B: r = (a < b) ? 32'd1 : 32'd0;
         6'h10: r = m_hi;
         6'h12: r = m_lo;
         6'h18: begin
            p    = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
            r    = m_lo;
            lat  = W;
         end
         6'h19: begin
            p    = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
            r    = m_lo;
            lat  = W;
         end
         6'h1A, 6'h1B: begin
            if (b == '0) begin
               m_hi = a;
               m_lo = '1;
            end else if (f == 6'h1A) begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
               lat  = W;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
               lat  = W;
            end
            r = m_lo;
         end
         default: r = '0;
      endcase
   endtask

   // Drive one request, wait for its valid, check every output and the pulse.
   task automatic run_op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] er;
      logic         eo;
      int           lat;
      int           cyc;
      model_op(opc, fn, a, b, er, eo, lat);
      @(negedge clk);
      start      = 1'b1;
      opcode     = opc;
      func_field = fn;
      A          = a;
      B          = b;
      @(posedge clk);
      #1;
      start      = 1'b0;
      A          = $urandom;
      B          = $urandom;
      opcode     = 6'($urandom);
      func_field = 6'($urandom);
      if (lat > 0) check({tag, "_busy"}, 64'(ready), 64'd0);
      cyc = 0;
      while (valid !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_lat"},    64'(cyc),      64'(lat));
      check({tag, "_result"}, 64'(result),   64'(er));
      check({tag, "_zero"},   64'(zero),     64'(er == '0));
      check({tag, "_ovf"},    64'(overflow), 64'(eo));
      check({tag, "_hi"},     64'(hi),       64'(m_hi));
      check({tag, "_lo"},     64'(lo),       64'(m_lo));
      check({tag, "_ready"},  64'(ready),    64'd1);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(valid),  64'd0);
      check({tag, "_hold"},  64'(result), 64'(er));
   endtask

   logic [5:0] op_tab [0:23];
   logic [5:0] fn_tab [0:23];

   initial begin
      logic [W-1:0] er;
      logic         eo;
      int           lat;
      int           vcount;
      int           k;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      total = 0;
      bad   = 0;
      m_hi  = '0;
      m_lo  = '0;
      op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                 6'h08, 6'h0C, 6'h0A, 6'h0B, 6'h05, 6'h2B, 6'h00, 6'h3F};
      fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B,
                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3E, 6'h20};

      // Reset
      rst        = 1'b1;
      start      = 1'b0;
      opcode     = '0;
      func_field = '0;
      A          = '0;
      B          = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready",  64'(ready),    64'd1);
      check("rst_valid",  64'(valid),    64'd0);
      check("rst_result", 64'(result),   64'd0);
      check("rst_zero",   64'(zero),     64'd0);
      check("rst_ovf",    64'(overflow), 64'd0);
      check("rst_hi",     64'(hi),       64'd0);
      check("rst_lo",     64'(lo),       64'd0);

      // Directed cases
      run_op("add_ovf",  6'h00, 6'h20, 32'h7FFFFFFF, 32'h1);
      run_op("beq",      6'h04, 6'h00, 32'h1234, 32'h1234);
      run_op("sub_ovf",  6'h00, 6'h22, 32'h80000000, 32'h1);
      run_op("mult",     6'h00, 6'h18, 32'hFFFFFFFD, 32'h5);
      run_op("mfhi",     6'h00, 6'h10, 32'h0, 32'h0);
      run_op("mflo",     6'h00, 6'h12, 32'h0, 32'h0);
      run_op("div",      6'h00, 6'h1A, 32'hFFFFFFF9, 32'h2);
      run_op("divu_z",   6'h00, 6'h1B, 32'h64, 32'h0);
      run_op("div_mn",   6'h00, 6'h1A, 32'h80000000, 32'hFFFFFFFF);
      run_op("div_rs",   6'h00, 6'h1A, 32'h7, 32'hFFFFFFFE);
      run_op("multu",    6'h00, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("bad_code", 6'h3F, 6'h00, 32'h5, 32'h6);

      // Back-to-back single-cycle ops with start held high
      @(negedge clk);
      start = 1'b1; opcode = 6'h00; func_field = 6'h21; A = 32'h10; B = 32'h20;
      @(posedge clk);
      #1;
      check("b2b_v1", 64'(valid),  64'd1);
      check("b2b_r1", 64'(result), 64'h30);
      @(negedge clk);
      func_field = 6'h26; A = 32'hF0F0; B = 32'h0FF0;
      @(posedge clk);
      #1;
      check("b2b_v2", 64'(valid),  64'd1);
      check("b2b_r2", 64'(result), 64'hFF00);
      start = 1'b0;

      // Start while busy must be ignored
      model_op(6'h00, 6'h19, 32'h12345678, 32'h9ABCDEF0, er, eo, lat);
      @(negedge clk);
      start = 1'b1; opcode = 6'h00; func_field = 6'h19; A = 32'h12345678; B = 32'h9ABCDEF0;
      @(posedge clk);
      #1;
      func_field = 6'h1B; A = 32'h1; B = 32'h0;
      vcount = 0;
      for (int i = 0; i < W + 8; i++) begin
         if (i == 6) start = 1'b0;
         @(posedge clk);
         #1;
         if (valid === 1'b1) vcount++;
      end
      check("busy_count", 64'(vcount), 64'd1);
      check("busy_hi",    64'(hi),     64'(m_hi));
      check("busy_lo",    64'(lo),     64'(m_lo));
      check("busy_res",   64'(result), 64'(er));

      // Reset in the middle of a DIVU
      @(negedge clk);
      start = 1'b1; opcode = 6'h00; func_field = 6'h1B; A = 32'hDEADBEEF; B = 32'h3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 64'(ready),  64'd1);
      check("mid_rst_valid", 64'(valid),  64'd0);
      check("mid_rst_hi",    64'(hi),     64'd0);
      check("mid_rst_lo",    64'(lo),     64'd0);
      check("mid_rst_res",   64'(result), 64'd0);
      @(negedge clk);
      rst  = 1'b0;
      m_hi = '0;
      m_lo = '0;
      run_op("sltu_post", 6'h00, 6'h2B, 32'h1, 32'h2);

      // Random operations
      for (int i = 0; i < 60; i++) begin
         k  = $urandom_range(0, 23);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: ra = 32'h80000000;
            2: rb = 32'hFFFFFFFF;
            3: rb = ra;
            default: ;
         endcase
         run_op("rand", op_tab[k], fn_tab[k], ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
